// File: rtl/game_mmio_pkg.sv
// Shared constants, direction codes and timer state for the game-object MMIO controller.
package game_mmio_pkg;

    localparam int DMEM_LIMIT   = 4096;
    localparam int INPUT_BASE   = 4100;
    localparam int PLAYER_BASE  = 4200;
    localparam int POWERUP_BASE = 4300;
    localparam logic [31:0] DESPAWN = 32'hFFFF_FFFF;

    localparam logic [3:0] DIR_NONE  = 4'd0;
    localparam logic [3:0] DIR_UP    = 4'd1;
    localparam logic [3:0] DIR_RIGHT = 4'd2;
    localparam logic [3:0] DIR_DOWN  = 4'd3;
    localparam logic [3:0] DIR_LEFT  = 4'd4;

    typedef enum logic {T_IDLE, T_ACTIVE} tmr_state_t;

    // {left,down,right,up}; chords and no-press both read as DIR_NONE
    function automatic logic [3:0] dir_code(input logic [3:0] d);
        case (d)
            4'b0001: dir_code = DIR_UP;
            4'b0010: dir_code = DIR_RIGHT;
            4'b0100: dir_code = DIR_DOWN;
            4'b1000: dir_code = DIR_LEFT;
            default: dir_code = DIR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/game_mmio_ctrl_timer.sv
// Per-player power-up duration timer: prescaler ticks drive a stage counter,
// power_id clears on the edge the last stage completes.
module powerup_timer
    import game_mmio_pkg::*;
#(
    parameter int TICK_CYCLES = 100000000,
    parameter int STAGES      = 7
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] id,
    output logic [3:0] power_id
);

    localparam logic [31:0] TICK_LAST  = 32'(TICK_CYCLES - 1);
    localparam logic [31:0] STAGE_LAST = 32'(STAGES - 1);

    tmr_state_t  state, state_n;
    logic [31:0] presc, presc_n;
    logic [31:0] stage, stage_n;
    logic [3:0]  pid_n;

    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            state    <= T_IDLE;
            presc    <= '0;
            stage    <= '0;
            power_id <= '0;
        end else begin
            state    <= state_n;
            presc    <= presc_n;
            stage    <= stage_n;
            power_id <= pid_n;
        end
    end

    always_comb begin
        state_n = state;
        presc_n = presc;
        stage_n = stage;
        pid_n   = power_id;
        if (start) begin
            // a new hit always restarts, even mid-duration
            state_n = T_ACTIVE;
            presc_n = '0;
            stage_n = '0;
            pid_n   = id;
        end else if (state == T_ACTIVE) begin
            if (presc == TICK_LAST) begin
                presc_n = '0;
                if (stage == STAGE_LAST) begin
                    state_n = T_IDLE;
                    stage_n = '0;
                    pid_n   = '0;
                end else begin
                    stage_n = stage + 32'd1;
                end
            end else begin
                presc_n = presc + 32'd1;
            end
        end
    end

endmodule

// File: rtl/game_mmio_ctrl.sv
// Game-object MMIO block: address decode, player/power-up coordinate registers,
// load-path mux and a one-pair-per-cycle collision scanner feeding per-player timers.
module game_mmio_ctrl
    import game_mmio_pkg::*;
#(
    parameter int NUM_PLAYERS  = 2,
    parameter int NUM_POWERUPS = 1,
    parameter int OBJ_W        = 32,
    parameter int OBJ_H        = 32,
    parameter int TICK_CYCLES  = 100000000,
    parameter int STAGES       = 7,
    parameter int PX0          = 240,
    parameter int PY0          = 240,
    parameter int PSTEP        = -140,
    parameter int UX0          = 300,
    parameter int UY0          = 300,
    parameter int USTEP        = 64
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [16:0]               address_dmem,
    input  logic [31:0]               data,
    input  logic                      wren,
    input  logic [31:0]               q_dmem,
    input  logic [4*NUM_PLAYERS-1:0]  dir_in,
    output logic [31:0]               proc_data_in,
    output logic                      dmem_wren,
    output logic [32*NUM_PLAYERS-1:0] player_x,
    output logic [32*NUM_PLAYERS-1:0] player_y,
    output logic [32*NUM_POWERUPS-1:0] powerup_x,
    output logic [32*NUM_POWERUPS-1:0] powerup_y,
    output logic [4*NUM_PLAYERS-1:0]  power_id
);

    localparam int NP = NUM_PLAYERS;
    localparam int NU = NUM_POWERUPS;
    localparam int PW = (NP > 1) ? $clog2(NP) : 1;
    localparam int UW = (NU > 1) ? $clog2(NU) : 1;

    logic [NP-1:0][31:0] px_q, py_q;
    logic [NU-1:0][31:0] ux_q, uy_q;
    logic [NP-1:0]       px_we, py_we, start_v;
    logic [NU-1:0]       ux_we, uy_we;
    logic [31:0]         rd_val, rd_q;
    logic                sel_dmem_q;
    logic [PW-1:0]       sp;
    logic [UW-1:0]       su;
    logic [32:0]         pxe, pye, uxe, uye;
    logic                hit;
    logic [3:0]          start_id;
    int                  addr_i;

    assign addr_i    = int'({15'd0, address_dmem});
    assign dmem_wren = wren && (addr_i < DMEM_LIMIT);
    assign player_x  = px_q;
    assign player_y  = py_q;
    assign powerup_x = ux_q;
    assign powerup_y = uy_q;

    always_comb begin
        rd_val = '0;
        px_we  = '0;
        py_we  = '0;
        ux_we  = '0;
        uy_we  = '0;
        for (int p = 0; p < NP; p++) begin
            if (addr_i == INPUT_BASE + p)
                rd_val = {28'd0, dir_code(dir_in[4*p +: 4])};
            if (addr_i == PLAYER_BASE + 3*p) begin
                rd_val   = px_q[p];
                px_we[p] = wren;
            end
            if (addr_i == PLAYER_BASE + 3*p + 1) begin
                rd_val   = py_q[p];
                py_we[p] = wren;
            end
            if (addr_i == PLAYER_BASE + 3*p + 2)
                rd_val = {28'd0, power_id[4*p +: 4]};
        end
        for (int u = 0; u < NU; u++) begin
            if (addr_i == POWERUP_BASE + 2*u) begin
                rd_val   = ux_q[u];
                ux_we[u] = wren;
            end
            if (addr_i == POWERUP_BASE + 2*u + 1) begin
                rd_val   = uy_q[u];
                uy_we[u] = wren;
            end
        end
    end

    // dmem already registers its read, so only its select is delayed here
    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            rd_q       <= '0;
            sel_dmem_q <= 1'b0;
        end else begin
            rd_q       <= rd_val;
            sel_dmem_q <= (addr_i < DMEM_LIMIT);
        end
    end

    assign proc_data_in = sel_dmem_q ? q_dmem : rd_q;

    // 33-bit compare so despawned (all-ones) objects cannot wrap into a hit
    assign pxe = {1'b0, px_q[sp]};
    assign pye = {1'b0, py_q[sp]};
    assign uxe = {1'b0, ux_q[su]};
    assign uye = {1'b0, uy_q[su]};
    assign hit = (pxe + 33'(OBJ_W) >= uxe) && (pxe <= uxe + 33'(OBJ_W)) &&
                 (pye + 33'(OBJ_H) >= uye) && (pye <= uye + 33'(OBJ_H));

    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            sp <= '0;
            su <= '0;
        end else if (su == UW'(NU - 1)) begin
            su <= '0;
            sp <= (sp == PW'(NP - 1)) ? '0 : sp + PW'(1);
        end else begin
            su <= su + UW'(1);
        end
    end

    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < NP; p++) begin
                px_q[p] <= 32'(PX0 + p*PSTEP);
                py_q[p] <= 32'(PY0 + p*PSTEP);
            end
            for (int u = 0; u < NU; u++) begin
                ux_q[u] <= 32'(UX0 + u*USTEP);
                uy_q[u] <= 32'(UY0);
            end
        end else begin
            for (int p = 0; p < NP; p++) begin
                if (px_we[p]) px_q[p] <= data;
                if (py_we[p]) py_q[p] <= data;
            end
            // a CPU store in the despawn cycle respawns that coordinate
            for (int u = 0; u < NU; u++) begin
                if (ux_we[u])                     ux_q[u] <= data;
                else if (hit && su == UW'(u))     ux_q[u] <= DESPAWN;
                if (uy_we[u])                     uy_q[u] <= data;
                else if (hit && su == UW'(u))     uy_q[u] <= DESPAWN;
            end
        end
    end

    always_comb begin
        start_v = '0;
        for (int p = 0; p < NP; p++)
            start_v[p] = hit && (sp == PW'(p));
    end

    assign start_id = 4'(su) + 4'd1;

    for (genvar g = 0; g < NP; g++) begin : gen_tmr
        powerup_timer #(
            .TICK_CYCLES(TICK_CYCLES),
            .STAGES     (STAGES)
        ) u_tmr (
            .clock   (clock),
            .reset   (reset),
            .start   (start_v[g]),
            .id      (start_id),
            .power_id(power_id[4*g +: 4])
        );
    end

endmodule

// File: tb/tb_game_mmio_ctrl.sv
// Directed-vector bench with a due-cycle scoreboard for game_mmio_ctrl (2x1 and 4x3 builds).
module tb_game_mmio_ctrl;

    localparam int S_RD = 0, S_PID = 1, S_UX0 = 2, S_UY0 = 3, S_PX0 = 4, S_PY1 = 5,
                   S_WREN = 6, S_PID2 = 7, S_UX2 = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [16:0] address_dmem = '0;
    logic [31:0] data = '0;
    logic        wren = 1'b0;
    logic [31:0] q_dmem = 32'hCAFE_0010;
    logic [7:0]  dir_in = '0;
    logic [31:0] proc_data_in;
    logic        dmem_wren;
    logic [63:0] player_x, player_y;
    logic [31:0] powerup_x, powerup_y;
    logic [7:0]  power_id;

    logic [16:0]  a2 = '0;
    logic [31:0]  d2 = '0;
    logic         w2 = 1'b0;
    logic [15:0]  dir2 = '0;
    logic [31:0]  pdi2;
    logic         dw2;
    logic [127:0] px2, py2;
    logic [95:0]  ux2, uy2;
    logic [15:0]  pid2;

    always #5 clock = ~clock;

    game_mmio_ctrl #(.TICK_CYCLES(4), .STAGES(2)) dut (
        .clock(clock), .reset(reset), .address_dmem(address_dmem), .data(data),
        .wren(wren), .q_dmem(q_dmem), .dir_in(dir_in), .proc_data_in(proc_data_in),
        .dmem_wren(dmem_wren), .player_x(player_x), .player_y(player_y),
        .powerup_x(powerup_x), .powerup_y(powerup_y), .power_id(power_id)
    );

    game_mmio_ctrl #(.NUM_PLAYERS(4), .NUM_POWERUPS(3), .TICK_CYCLES(1000), .STAGES(2)) dut2 (
        .clock(clock), .reset(reset), .address_dmem(a2), .data(d2),
        .wren(w2), .q_dmem(q_dmem), .dir_in(dir2), .proc_data_in(pdi2),
        .dmem_wren(dw2), .player_x(px2), .player_y(py2),
        .powerup_x(ux2), .powerup_y(uy2), .power_id(pid2)
    );

    typedef struct {
        string       nm;
        int          sel;
        logic [31:0] exp;
        int          due;
    } chk_t;

    chk_t sq[$];
    chk_t cq[$];
    int   cyc = 0;
    int   scan_k = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic logic [31:0] pick(input int sel);
        case (sel)
            S_RD:    return proc_data_in;
            S_PID:   return {24'd0, power_id};
            S_UX0:   return powerup_x;
            S_UY0:   return powerup_y;
            S_PX0:   return player_x[31:0];
            S_PY1:   return player_y[63:32];
            S_WREN:  return {31'd0, dmem_wren};
            S_PID2:  return {16'd0, pid2};
            S_UX2:   return ux2[95:64];
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    function automatic void compare(input chk_t c);
        logic [31:0] act;
        act = pick(c.sel);
        n_vec++;
        if (act !== c.exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", c.nm, act, c.exp, cyc);
        end
    endfunction

    // combinational checks at the falling edge, then count the edge
    always @(negedge clock) begin
        while (cq.size() > 0 && cq[0].due <= cyc) compare(cq.pop_front());
        cyc++;
        if (reset) scan_k = 0;
        else       scan_k++;
    end

    // registered checks half a cycle after the edge they depend on
    always @(posedge clock) begin
        while (sq.size() > 0 && sq[0].due <= cyc) compare(sq.pop_front());
    end

    function automatic void exp_s(input string nm, input int sel, input logic [31:0] e);
        sq.push_back('{nm, sel, e, cyc + 1});
    endfunction

    function automatic void exp_c(input string nm, input int sel, input logic [31:0] e);
        cq.push_back('{nm, sel, e, cyc});
    endfunction

    task automatic drive(input logic [16:0] a, input logic [31:0] d, input logic we);
        @(posedge clock);
        #1;
        address_dmem = a;
        data         = d;
        wren         = we;
    endtask

    task automatic idle();
        drive(17'd0, 32'd0, 1'b0);
    endtask

    task automatic drive2(input logic [16:0] a, input logic [31:0] d, input logic we);
        @(posedge clock);
        #1;
        a2 = a;
        d2 = d;
        w2 = we;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        // reset state
        idle();
        exp_s("rst_rd", S_RD, 32'd0);
        exp_s("rst_pid", S_PID, 32'd0);
        exp_s("rst_ux0", S_UX0, 32'd300);
        exp_s("rst_py1", S_PY1, 32'd100);
        drive(17'd4200, 32'd0, 1'b0); reset = 1'b0;
        exp_s("ld_4200_rst", S_RD, 32'd240);

        // input decode
        drive(17'd4100, 0, 0); dir_in = 8'h01; exp_s("in_up", S_RD, 32'd1);
        drive(17'd4100, 0, 0); dir_in = 8'h09; exp_s("in_up_left", S_RD, 32'd0);
        drive(17'd4101, 0, 0); dir_in = 8'h20; exp_s("in_p1_right", S_RD, 32'd2);
        drive(17'd4100, 0, 0); dir_in = 8'h04; exp_s("in_down", S_RD, 32'd3);
        drive(17'd4100, 0, 0); dir_in = 8'h08; exp_s("in_left", S_RD, 32'd4);
        drive(17'd4100, 0, 0); dir_in = 8'h00; exp_s("in_none", S_RD, 32'd0);

        // RO / unmapped / dmem stores
        drive(17'd4202, 32'd7, 1'b1); exp_c("wren_ro", S_WREN, 32'd0);
        drive(17'd4202, 0, 0);        exp_s("ro_kept", S_RD, 32'd0);
        drive(17'd4500, 32'd7, 1'b1); exp_c("wren_unmapped", S_WREN, 32'd0);
        exp_s("px0_kept", S_PX0, 32'd240);
        drive(17'd4500, 0, 0);        exp_s("unmapped_rd", S_RD, 32'd0);
        drive(17'd10, 32'd5, 1'b1);   exp_c("wren_dmem", S_WREN, 32'd1);
        drive(17'd4095, 32'd5, 1'b1); exp_c("wren_4095", S_WREN, 32'd1);
        drive(17'd4096, 32'd5, 1'b1); exp_c("wren_4096", S_WREN, 32'd0);
        drive(17'd10, 0, 0);          exp_s("dmem_rd", S_RD, 32'hCAFE_0010);

        // collision and exact timer duration (hit lands on the edge after the y store)
        drive(17'd4200, 32'd300, 1'b1);
        drive(17'd4200, 0, 0);        exp_s("px0_wr_rd", S_RD, 32'd300);
        do idle(); while (scan_k % 2 != 0);
        drive(17'd4201, 32'd300, 1'b1); exp_s("pid_pre_hit", S_PID, 32'd0);
        idle();                          exp_s("pid_hit", S_PID, 32'd1);
        exp_s("ux0_despawn", S_UX0, 32'hFFFF_FFFF);
        drive(17'd4300, 0, 0);           exp_s("ld_4300_desp", S_RD, 32'hFFFF_FFFF);
        drive(17'd4202, 0, 0);           exp_s("ld_4202_pid", S_RD, 32'd1);
        repeat (4) idle();
        idle();                          exp_s("pid_hold_7", S_PID, 32'd1);
        idle();                          exp_s("pid_expire_8", S_PID, 32'd0);

        // CPU store to x in the despawn cycle
        drive(17'd4300, 32'd300, 1'b1);
        do idle(); while (scan_k % 2 != 0);
        drive(17'd4301, 32'd300, 1'b1);
        drive(17'd4300, 32'd50, 1'b1);
        exp_s("ux0_cpu_wins", S_UX0, 32'd50);
        exp_s("uy0_despawn", S_UY0, 32'hFFFF_FFFF);
        exp_s("pid_sim", S_PID, 32'd1);

        // reset while timer active
        drive(17'd4200, 0, 0); reset = 1'b1;
        exp_s("rstm_pid", S_PID, 32'd0);
        exp_s("rstm_px0", S_PX0, 32'd240);
        exp_s("rstm_ux0", S_UX0, 32'd300);
        exp_s("rstm_uy0", S_UY0, 32'd300);
        exp_s("rstm_rd", S_RD, 32'd0);
        drive(17'd4200, 0, 0); reset = 1'b0;
        exp_s("rstm_ld_4200", S_RD, 32'd240);
        drive(17'd4203, 0, 0);
        exp_s("rstm_ld_4203", S_RD, 32'd100);

        // 4x3 build: player 3 onto power-up 2 at (428,300)
        drive2(17'd4209, 32'd428, 1'b1);
        drive2(17'd4210, 32'd300, 1'b1);
        exp_s("pid2_pre", S_PID2, 32'd0);
        repeat (11) drive2(17'd0, 32'd0, 1'b0);
        drive2(17'd0, 32'd0, 1'b0);
        exp_s("pid2_p3_u2", S_PID2, 32'h0000_3000);
        exp_s("ux2_u2_despawn", S_UX2, 32'hFFFF_FFFF);

        repeat (3) idle();
        if (sq.size() > 0 || cq.size() > 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: got %0d pending checks, expected 0", sq.size() + cq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
